sbox_layer: RTL and testbench
=============================

# sbox_layer

Round-key addition and S-box substitution stage of the PRESENT round datapath. It sits directly upstream of the bit-permutation stage, and its `out`/`enable_out` connect straight to that stage's `state`/`enable_in`. On a start pulse it XORs the 64-bit state with the 64-bit round key. It then applies the 4-bit PRESENT S-box to all 16 nibbles, `NIBBLES_PER_CYCLE` nibbles per clock, so area and latency can be traded.

## Interface
- `NIBBLES_PER_CYCLE`, default 4: S-boxes instantiated, i.e. nibbles substituted per clock.
  - Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- `clock`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `state`: input, 64 bits. Round input state; sampled only on the accept edge.
- `round_key`: input, 64 bits. Round key; sampled only on the accept edge.
- `enable_in`: input, 1 bit. Start request, level-sampled each edge.
- `out`: output, 64 bits, registered. Substituted state; holds its value until the next completion.
- `enable_out`: output, 1 bit, registered. One-cycle pulse marking `out` valid; feeds the permutation stage's `enable_in`.
- `busy`: output, 1 bit, registered. High while an operation is in flight.

## Operation
- Internal registers:
  - `work[63:0]`: working state.
  - Nibble counter: width `$clog2(16/NIBBLES_PER_CYCLE)`, minimum 1 bit.
  - Two-state FSM: IDLE / RUN. `busy` is 1 exactly when the FSM is in RUN.
- S-box, input 0..F maps to: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- IDLE:
  - An edge with `enable_in`=1 is the accept edge. On it: `work <= state ^ round_key`, counter <= 0, go to RUN.
  - `enable_in`=0: nothing changes.
- RUN, each edge:
  - Nibbles `[c*N .. c*N+N-1]` of `work` are replaced by their S-box images (nibble i = bits `4i+3:4i`, lowest nibble first). Here c is the counter and N is `NIBBLES_PER_CYCLE`.
  - The counter increments. All other nibbles are held.
- Last chunk (c = 16/N-1), on the same edge:
  - `out` <= the fully substituted value (the last chunk is substituted combinationally into the value written).
  - `enable_out` <= 1; FSM returns to IDLE; counter <= 0.
- `enable_out` is 1 for exactly one cycle, then returns to 0.
- `enable_in` is ignored while in RUN, including on the completion edge. A request arriving then is dropped, not queued; upstream must wait for `busy`=0.
- `out` changes only on completion edges. `work` holds its value in IDLE.
- Reset (asynchronous assert, any state including mid-RUN):
  - `out`=0, `enable_out`=0, `busy`=0, `work`=0, counter=0, FSM=IDLE.
  - An aborted operation never produces `enable_out`.
- Release of `reset_n` is synchronised externally. The first edge after release may accept `enable_in`.

## Timing
- Latency: 16/N rising edges from the accept edge to the edge that raises `enable_out`.
  - N=16: 1 cycle. N=4: 4 cycles. N=1: 16 cycles.
- `busy` rises on the accept edge and falls on the completion edge, coincident with `enable_out` rising.
- Maximum throughput: one result per 16/N+1 cycles. The earliest next accept is the edge where `enable_out` is high.
  - So `enable_in` held permanently high yields back-to-back operations with one IDLE cycle between them.
- No combinational path from any input to any output.

## Test plan
- Reset and basic substitution:
  - Stimulus: reset, then `state`=0, `round_key`=0, one-cycle `enable_in`, N=4.
  - Required: `out`=0xCCCCCCCCCCCCCCCC with `enable_out` pulsed once, exactly 4 edges after accept; `busy` high for exactly those 4 cycles.
- All 16 S-box entries, every legal N:
  - Stimulus: `state`=0x0123456789ABCDEF, `round_key`=0, repeated for N = 1, 2, 4, 8, 16.
  - Required: `out`=0xC56B90AD3EF84712 at latency 16, 8, 4, 2, 1 respectively.
- Key addition:
  - Stimulus: `state`=0xFFFFFFFFFFFFFFFF, `round_key`=0xFEDCBA9876543210.
  - Required: `out`=0xC56B90AD3EF84712.
  - Also: `state`=0xFFFFFFFFFFFFFFFF, `round_key`=0 gives `out`=0x2222222222222222.
- Input sampling and busy handling:
  - Stimulus: change `state`/`round_key` and pulse `enable_in` while `busy`=1.
  - Required: the result reflects only the values present on the accept edge; no second operation starts; `out` is unchanged until the completion edge.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 two cycles after accept (N=4).
  - Required: `out`, `busy` and `enable_out` go to 0 immediately (asynchronously); no `enable_out` pulse follows; a fresh request afterwards completes normally.
- Back-to-back requests:
  - Stimulus: `enable_in` held high for 20 cycles with N=4.
  - Required: `enable_out` pulses every 5 cycles, and each result matches the inputs on its own accept edge.

Source files
------------

// File: rtl/sbox_layer.sv
// sbox_layer: PRESENT round-key addition and S-box substitution.
// Substitutes NIBBLES_PER_CYCLE nibbles of the keyed state per clock.
module sbox_layer #(
  parameter int NIBBLES_PER_CYCLE = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] state,
  input  logic [63:0] round_key,
  input  logic        enable_in,
  output logic [63:0] out,
  output logic        enable_out,
  output logic        busy
);

  localparam int N      = NIBBLES_PER_CYCLE;
  localparam int CHUNKS = 16 / N;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (!(N == 1 || N == 2 || N == 4 ||
        N == 8 || N == 16)) begin : g_bad_n
    $error("sbox_layer: NIBBLES_PER_CYCLE must be 1/2/4/8/16");
  end

  logic [0:0]    fsm_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   work_q;
  logic [63:0]   sub;
  logic          last;

  function automatic logic [3:0] sbox(
    input logic [3:0] x
  );
    logic [3:0] r;
    r = 4'h0;
    case (x)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      4'hF: r = 4'h2;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Substitute the chunk selected by the counter, hold the rest
  always_comb begin
    sub = work_q;
    for (int i = 0; i < 16; i++) begin
      if ((i / N) == int'(cnt_q)) begin
        sub[4*i +: 4] = sbox(work_q[4*i +: 4]);
      end
    end
  end

  assign last = (cnt_q == LAST);
  assign busy = (fsm_q == RUN);

  // Accept, chunked substitution and completion sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      out        <= '0;
      enable_out <= 1'b0;
    end else begin
      enable_out <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (enable_in) begin
            work_q <= state ^ round_key;
            cnt_q  <= '0;
            fsm_q  <= RUN;
          end
        end
        RUN: begin
          work_q <= sub;
          if (last) begin
            out        <= sub;
            enable_out <= 1'b1;
            cnt_q      <= '0;
            fsm_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          fsm_q <= IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_layer.sv
// tb_sbox_layer: checks sbox_layer for every legal N at once.
// Instance g uses NIBBLES_PER_CYCLE = 1<<g; latency is 16>>g.
module tb_sbox_layer;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic [63:0] state     = '0;
  logic [63:0] round_key = '0;
  logic        enable_in = 1'b0;

  logic [63:0] o [5];
  logic [4:0]  eo;
  logic [4:0]  bz;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  always #5 clock = ~clock;

  for (genvar g = 0; g < 5; g++) begin : gi
    sbox_layer #(
      .NIBBLES_PER_CYCLE(1 << g)
    ) u (
      .clock      (clock),
      .reset_n    (reset_n),
      .state      (state),
      .round_key  (round_key),
      .enable_in  (enable_in),
      .out        (o[g]),
      .enable_out (eo[g]),
      .busy       (bz[g])
    );
  end

  function automatic logic [63:0] ref_sub(
    input logic [63:0] s,
    input logic [63:0] k
  );
    logic [63:0] x;
    logic [63:0] r;
    x = s ^ k;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = SB[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation on all instances; inj>0 pulses a junk request on edge inj
  task automatic op(
    input logic [63:0] s,
    input logic [63:0] k,
    input int          inj,
    input string       tag
  );
    int          lat   [5];
    int          pls   [5];
    int          bcnt  [5];
    int          badch [5];
    logic [63:0] prev  [5];
    logic [63:0] got   [5];
    logic [63:0] exp;
    exp = ref_sub(s, k);
    for (int g = 0; g < 5; g++) begin
      lat[g] = -1; pls[g] = 0; bcnt[g] = 0;
      badch[g] = 0; prev[g] = o[g]; got[g] = 'x;
    end
    state = s; round_key = k; enable_in = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        if (c == inj) begin
          enable_in = 1'b1;
          state = rnd64(); round_key = rnd64();
        end else begin
          enable_in = 1'b0;
        end
      end
      step();
      for (int g = 0; g < 5; g++) begin
        if (bz[g]) bcnt[g]++;
        if (eo[g]) begin
          pls[g]++; lat[g] = c; got[g] = o[g];
        end
        if (o[g] !== prev[g]) begin
          if (!eo[g]) badch[g]++;
          prev[g] = o[g];
        end
      end
    end
    enable_in = 1'b0;
    for (int g = 0; g < 5; g++) begin
      if (inj == 0 || (16 >> g) >= inj) begin
        chk($sformatf("%s_lat_n%0d", tag, 1 << g),
            64'(lat[g]), 64'(16 >> g));
        chk($sformatf("%s_pulses_n%0d", tag, 1 << g),
            64'(pls[g]), 64'd1);
        chk($sformatf("%s_busy_n%0d", tag, 1 << g),
            64'(bcnt[g]), 64'(16 >> g));
        chk($sformatf("%s_out_n%0d", tag, 1 << g),
            got[g], exp);
        chk($sformatf("%s_hold_n%0d", tag, 1 << g),
            64'(badch[g]), 64'd0);
      end
    end
  endtask

  int          rem  [5];
  logic [63:0] mexp [5];
  logic [4:0]  pexp;
  int          pc;
  int          stray;

  initial begin
    // Reset state
    reset_n = 1'b0;
    #12;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rst_out_n%0d", 1 << g), o[g], 64'd0);
      chk($sformatf("rst_eo_n%0d", 1 << g), 64'(eo[g]), 64'd0);
      chk($sformatf("rst_busy_n%0d", 1 << g), 64'(bz[g]), 64'd0);
    end
    step();
    reset_n = 1'b1;

    // Directed substitutions
    op(64'h0, 64'h0, 0, "zero");
    chk("zero_value", o[2], 64'hCCCCCCCCCCCCCCCC);
    op(64'h0123456789ABCDEF, 64'h0, 0, "all16");
    chk("all16_value", o[0], 64'hC56B90AD3EF84712);
    op(64'hFFFFFFFFFFFFFFFF, 64'hFEDCBA9876543210, 0, "keyadd");
    chk("keyadd_value", o[4], 64'hC56B90AD3EF84712);
    op(64'hFFFFFFFFFFFFFFFF, 64'h0, 0, "ones");
    chk("ones_value", o[3], 64'h2222222222222222);

    // Requests and input changes while busy are ignored
    op(rnd64(), rnd64(), 2, "busyinj");

    // Reset two cycles into an N=4 operation
    state = 64'h0123456789ABCDEF; round_key = 64'h0;
    enable_in = 1'b1;
    step();
    enable_in = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out", o[2], 64'd0);
    chk("midrst_busy", 64'(bz[2]), 64'd0);
    chk("midrst_eo", 64'(eo[2]), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (eo != 5'd0) stray++;
    end
    chk("midrst_no_pulse", 64'(stray), 64'd0);
    op(rnd64(), rnd64(), 0, "afterrst");

    // Back-to-back with enable_in held high, then drained
    for (int g = 0; g < 5; g++) rem[g] = 0;
    pc = 0;
    for (int c = 0; c < 40; c++) begin
      enable_in = (c < 20);
      state = rnd64(); round_key = rnd64();
      for (int g = 0; g < 5; g++) begin
        pexp[g] = 1'b0;
        if (rem[g] == 0) begin
          if (enable_in) begin
            mexp[g] = ref_sub(state, round_key);
            rem[g] = 16 >> g;
          end
        end else begin
          rem[g]--;
          if (rem[g] == 0) pexp[g] = 1'b1;
        end
      end
      step();
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("b2b_eo_n%0d_c%0d", 1 << g, c),
            64'(eo[g]), 64'(pexp[g]));
        if (pexp[g])
          chk($sformatf("b2b_out_n%0d_c%0d", 1 << g, c),
              o[g], mexp[g]);
      end
      if (eo[2]) pc++;
    end
    enable_in = 1'b0;
    chk("b2b_n4_pulses", 64'(pc), 64'd4);

    // Random single operations
    for (int r = 0; r < 4; r++)
      op(rnd64(), rnd64(), 0, $sformatf("rand%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
